// File: rtl/detector_stream_arbiter.sv
// ---------------------------------------------------------------------------
// detector_stream_arbiter
//
// Shares one external serial ones-counting detector among NREQ requesters.
// A round-robin arbiter picks one requester and clears the detector for one
// cycle. It then streams that requester's burst of req_len bits into det_ins,
// and returns the detector output sampled after the last bit, with a
// one-cycle done pulse. If the owner drops req mid-burst, a one-cycle abort
// pulse replaces done.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   req[NREQ]         per-requester request, held until own done/abort
//   req_len           packed burst lengths, slice i = req_len[i*LEN_W +: LEN_W]
//   data_bit/valid    per-requester serial data and valid
//   data_ready        per-requester accept (only the owner, only while streaming)
//   grant             one-hot current owner, registered
//   det_reset/det_ins control of the shared detector
//   det_outs          detector output (Moore)
//   busy              high from grant until release
//   done/result       completion pulse and captured detector output
//   done_id           requester that completed or aborted
//   abort             pulse: owner dropped req during CLEAR/STREAM
// ---------------------------------------------------------------------------
module detector_stream_arbiter #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic [NREQ-1:0]         data_bit,
    input  logic [NREQ-1:0]         data_valid,
    output logic [NREQ-1:0]         data_ready,
    output logic [NREQ-1:0]         grant,
    output logic                    det_reset,
    output logic                    det_ins,
    input  logic                    det_outs,
    output logic                    busy,
    output logic                    done,
    output logic                    result,
    output logic [2:0]              done_id,
    output logic                    abort
);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, CAPTURE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [2:0]         owner_reg, owner_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic [NREQ-1:0]    grant_reg, grant_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               result_reg, result_next;
    logic [2:0]         done_id_reg, done_id_next;
    logic               abort_reg, abort_next;

    // Inputs widened to 8 lanes so a 3-bit owner index selects them exactly.
    logic [7:0]         req8, valid8, bit8;
    logic [LEN_W-1:0]   len_arr [8];
    logic               owner_req, owner_valid, owner_bit;

    logic               arb_found;
    logic [2:0]         arb_idx;
    logic [3:0]         arb_cand;
    logic [NREQ-1:0]    grant_dec;
    logic [NREQ-1:0]    ready_dec;

    assign req8   = 8'(req);
    assign valid8 = 8'(data_valid);
    assign bit8   = 8'(data_bit);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_len
            if (gi < NREQ) begin : g_act
                assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
            end else begin : g_pad
                assign len_arr[gi] = '0;
            end
        end
        for (gi = 0; gi < NREQ; gi++) begin : g_dec
            assign grant_dec[gi] = (arb_idx == 3'(gi));
            assign ready_dec[gi] = (owner_reg == 3'(gi));
        end
    endgenerate

    assign owner_req   = req8[owner_reg];
    assign owner_valid = valid8[owner_reg];
    assign owner_bit   = bit8[owner_reg];

    // Round-robin search: ptr+1, ptr+2, ... modulo NREQ; the first set req wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_cand = {1'b0, ptr_reg} + 4'(k);
            if (arb_cand >= 4'(NREQ)) begin
                arb_cand = arb_cand - 4'(NREQ);
            end
            if (!arb_found && req8[arb_cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand[2:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= 3'(NREQ-1);
            owner_reg   <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            grant_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= 1'b0;
            done_id_reg <= '0;
            abort_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            grant_reg   <= grant_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            result_reg  <= result_next;
            done_id_reg <= done_id_next;
            abort_reg   <= abort_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        owner_next   = owner_reg;
        len_next     = len_reg;
        cnt_next     = cnt_reg;
        grant_next   = grant_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        result_next  = result_reg;
        done_id_next = done_id_reg;
        abort_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_next = grant_dec;
                    busy_next  = 1'b1;
                    owner_next = arb_idx;
                    ptr_next   = arb_idx;
                    len_next   = len_arr[arb_idx];
                    cnt_next   = '0;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cnt_next = '0;
                if (!owner_req) begin
                    abort_next   = 1'b1;
                    done_id_next = owner_reg;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else if (len_reg != '0) begin
                    state_next = STREAM;
                end else begin
                    state_next = CAPTURE;
                end
            end
            STREAM: begin
                // A dropped request wins over a beat presented in the same cycle.
                if (!owner_req) begin
                    abort_next   = 1'b1;
                    done_id_next = owner_reg;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else if (owner_valid) begin
                    if (cnt_reg == len_reg - LEN_W'(1)) begin
                        state_next = CAPTURE;
                    end else begin
                        cnt_next = cnt_reg + LEN_W'(1);
                    end
                end
            end
            CAPTURE: begin
                // The detector took the last bit at the previous edge, so det_outs is final here.
                result_next  = det_outs;
                done_next    = 1'b1;
                done_id_next = owner_reg;
                grant_next   = '0;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. det_reset also follows the reset input directly, so the
    // detector is cleared asynchronously along with this block.
    always_comb begin
        data_ready = '0;
        det_ins    = 1'b0;
        det_reset  = 1'b0;
        case (state_reg)
            CLEAR: begin
                det_reset = 1'b1;
            end
            STREAM: begin
                data_ready = ready_dec;
                det_ins    = owner_bit & owner_valid & owner_req;
            end
            default: begin
            end
        endcase
        if (reset) begin
            det_reset  = 1'b1;
            data_ready = '0;
            det_ins    = 1'b0;
        end
    end

    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign done_id = done_id_reg;
    assign abort   = abort_reg;

endmodule

// File: tb/tb_detector_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_detector_stream_arbiter
//
// Directed bench for detector_stream_arbiter. The shared detector is modelled
// here as a ones counter modulo 3 whose output is high in state S0 (after a
// reset, or after 3, 6, ... ones). Behavioural requesters answer data_ready.
// Each test pushes its hand-computed completions into a queue, and a separate
// monitor pops and compares one entry whenever done or abort pulses.
// ---------------------------------------------------------------------------
module tb_detector_stream_arbiter;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        data_bit;
    logic [NREQ-1:0]        data_valid;
    logic [NREQ-1:0]        data_ready;
    logic [NREQ-1:0]        grant;
    logic                   det_reset;
    logic                   det_ins;
    logic                   det_outs;
    logic                   busy;
    logic                   done;
    logic                   result;
    logic [2:0]             done_id;
    logic                   abort;

    always #5 clk = ~clk;

    detector_stream_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .data_bit(data_bit), .data_valid(data_valid), .data_ready(data_ready),
        .grant(grant), .det_reset(det_reset), .det_ins(det_ins), .det_outs(det_outs),
        .busy(busy), .done(done), .result(result), .done_id(done_id), .abort(abort)
    );

    // Shared detector model: ones counter mod 3, output high in S0.
    logic [1:0] det_state;
    always_ff @(posedge clk or posedge det_reset) begin
        if (det_reset)    det_state <= 2'd0;
        else if (det_ins) det_state <= (det_state == 2'd2) ? 2'd0 : det_state + 2'd1;
    end
    assign det_outs = (det_state == 2'd0);

    typedef struct {
        bit         is_abort;
        logic [2:0] id;
        bit         res;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Requester behaviour
    logic [15:0] bits      [NREQ];
    int          bidx      [NREQ];
    int          gap_pos   [NREQ];
    int          gap_left  [NREQ];
    int          drop_at   [NREQ];
    int          rereq     [NREQ];
    bit          acc_pend  [NREQ];
    int          ready_cyc [NREQ];
    int          rst_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push(input bit ab, input int id, input bit res);
        exp_t e;
        e.is_abort = ab;
        e.id       = 3'(id);
        e.res      = res;
        exp_q.push_back(e);
    endtask

    task automatic setup(input int i, input int len, input logic [15:0] b,
                         input int gp, input int gl, input int da, input int rr);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
        bits[i]     = b;
        bidx[i]     = 0;
        gap_pos[i]  = gp;
        gap_left[i] = gl;
        drop_at[i]  = da;
        rereq[i]    = rr;
        req[i]      = 1'b1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NREQ; i++) ready_cyc[i] = 0;
        rst_cyc = 0;
    endtask

    // One cycle of requester behaviour, driven on the falling edge.
    task automatic tick();
        bit stalled;
        @(negedge clk);
        stalled = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_pend[i]) bidx[i]++;
            if (done && done_id == 3'(i) && req[i]) begin
                if (rereq[i] > 0) begin
                    rereq[i]--;
                    bidx[i] = 0;
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            data_valid[i] = 1'b0;
            data_bit[i]   = 1'b0;
            if (req[i] && data_ready[i]) begin
                if (bidx[i] == drop_at[i]) begin
                    req[i]     = 1'b0;
                    drop_at[i] = 99;
                end else if (bidx[i] == gap_pos[i] && gap_left[i] > 0) begin
                    gap_left[i]--;
                    stalled = 1'b1;
                end else begin
                    data_valid[i] = 1'b1;
                    data_bit[i]   = bits[i][bidx[i]];
                end
            end
            acc_pend[i] = req[i] & data_valid[i] & data_ready[i];
            if (data_ready[i]) ready_cyc[i]++;
        end
        if (det_reset) rst_cyc++;
        #1;
        if (stalled) check("det_ins_in_gap", 32'(det_ins), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy || req != '0) && c < budget) begin
            tick();
            c++;
        end
        check("idle_within_budget", 32'(c < budget), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_grant"},      32'(grant),      32'd0);
        check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_det_reset"},  32'(det_reset),  32'd1);
        check({tag, "_det_ins"},    32'(det_ins),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_result"},     32'(result),     32'd0);
        check({tag, "_done_id"},    32'(done_id),    32'd0);
        check({tag, "_abort"},      32'(abort),      32'd0);
    endtask

    task automatic clear_reqs();
        req        = '0;
        data_valid = '0;
        data_bit   = '0;
        for (int i = 0; i < NREQ; i++) begin
            acc_pend[i] = 1'b0;
            bidx[i]     = 0;
            drop_at[i]  = 99;
            gap_left[i] = 0;
            rereq[i]    = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor
    bit last_res = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_res = 1'b0;
        end else begin
            n_tests++;
            if (!$onehot0(grant) || !$onehot0(data_ready) || (done && abort)) begin
                n_fail++;
                $display("[TB] FAIL onehot: grant=%b data_ready=%b done=%b abort=%b",
                         grant, data_ready, done, abort);
            end
            if (done || abort) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: done=%b abort=%b id=%0d, expected none",
                             done, abort, done_id);
                end else begin
                    e = exp_q.pop_front();
                    if (abort != e.is_abort || done_id != e.id ||
                        (!e.is_abort && result != e.res) ||
                        (e.is_abort && (grant != '0 || result != last_res))) begin
                        n_fail++;
                        $display("[TB] FAIL completion: got abort=%b id=%0d result=%b grant=%b, expected abort=%b id=%0d result=%b",
                                 abort, done_id, result, grant, e.is_abort, e.id,
                                 e.is_abort ? last_res : e.res);
                    end else begin
                        $display("[TB] %s id=%0d result=%b", abort ? "abort" : "done ",
                                 done_id, result);
                    end
                    if (!e.is_abort) last_res = e.res;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset   = 1'b1;
        req_len = '0;
        clear_reqs();
        clear_stats();
        repeat (2) @(negedge clk);
        #1;
        reset_checks("reset");
        reset = 1'b0;

        // 1: req0, len 3, bits 111 -> 3 ones -> S0 -> result 1
        clear_stats();
        setup(0, 3, 16'b111, 99, 0, 99, 0);
        push(0, 0, 1'b1);
        tick();
        check("t1_no_ready_in_clear", 32'(data_ready[0]), 32'd0);
        check("t1_det_reset_in_clear", 32'(det_reset), 32'd1);
        tick();
        check("t1_ready_after_2", 32'(data_ready[0]), 32'd1);
        wait_idle(50);
        check("t1_ready_cycles", 32'(ready_cyc[0]), 32'd3);

        // 2: req2, len 3, bits 1,0,1 with 2-cycle gap after first bit -> result 0
        clear_stats();
        setup(2, 3, 16'b101, 1, 2, 99, 0);
        push(0, 2, 1'b0);
        wait_idle(50);
        check("t2_ready_cycles", 32'(ready_cyc[2]), 32'd5);

        // 3: req1 and req3 from reset, len 4, bits 1111 -> result 0 each;
        //    req1 re-requests once but req3 is served before its second turn.
        do_reset();
        setup(1, 4, 16'hF, 99, 0, 99, 1);
        setup(3, 4, 16'hF, 99, 0, 99, 0);
        push(0, 1, 1'b0);
        push(0, 3, 1'b0);
        push(0, 1, 1'b0);
        wait_idle(100);

        // 4: req0, len 0 -> one clear cycle, no ready, result 1
        clear_stats();
        setup(0, 0, 16'h0, 99, 0, 99, 0);
        push(0, 0, 1'b1);
        wait_idle(50);
        check("t4_ready_cycles", 32'(ready_cyc[0]), 32'd0);
        check("t4_det_reset_cycles", 32'(rst_cyc), 32'd1);

        // 5: req1 len 5 drops after 2 beats -> abort id 1; req2 (len 1, bit 1) next -> result 0
        setup(1, 5, 16'h1F, 99, 0, 2, 0);
        setup(2, 1, 16'h1, 99, 0, 99, 0);
        push(1, 1, 1'b0);
        push(0, 2, 1'b0);
        wait_idle(100);

        // 6: reset during STREAM, then a fresh grant starts from requester 0
        setup(0, 5, 16'h1F, 99, 0, 99, 0);
        c = 0;
        while (bidx[0] < 2 && c < 30) begin
            tick();
            c++;
        end
        check("t6_reached_stream", 32'(c < 30), 32'd1);
        reset = 1'b1;
        #1;
        reset_checks("midreset");
        clear_reqs();
        @(negedge clk);
        check("t6_no_pending", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        setup(0, 2, 16'b11, 99, 0, 99, 0);
        setup(1, 1, 16'b0, 99, 0, 99, 0);
        push(0, 0, 1'b0);
        push(0, 1, 1'b1);
        tick();
        check("t6_first_grant", 32'(grant), 32'b0001);
        wait_idle(100);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
